// File: rtl/col_parity_theta_engine_pkg.sv
// Shared sizing helpers, FSM encodings and bit indexing for the column-parity theta engine.
package col_parity_pkg;

  localparam logic [0:0] ST_LOAD  = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;
  typedef logic [0:0] state_t;

  function automatic int line_w(input int rows, input int cols);
    return rows * cols;
  endfunction

  function automatic int cnt_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Lines are row-major: bit y*COLS+x holds row y, column x.
  function automatic int idx(input int y, input int x, input int cols);
    return y * cols + x;
  endfunction

endpackage

// File: rtl/col_parity_theta_engine_if.sv
// Line-source and output-stage handshake bundle for the column-parity theta engine.
interface col_parity_theta_engine_if import col_parity_pkg::*; #(
  parameter int ROWS  = 5,
  parameter int COLS  = 5,
  parameter int DEPTH = 64
);
  localparam int LINE_W = line_w(ROWS, COLS);
  localparam int CNT_W  = cnt_w(DEPTH);

  logic              mode;
  logic              dir_down;
  logic              in_valid;
  logic              in_ready;
  logic [LINE_W-1:0] in_line;
  logic              out_valid;
  logic              out_ready;
  logic [LINE_W-1:0] out_line;
  logic [COLS-1:0]   out_parity;
  logic [CNT_W-1:0]  out_z;
  logic              out_last;
  logic              busy;

  modport master (
    output mode, dir_down, in_valid, in_line, out_ready,
    input  in_ready, out_valid, out_line, out_parity, out_z, out_last, busy
  );

  modport slave (
    input  mode, dir_down, in_valid, in_line, out_ready,
    output in_ready, out_valid, out_line, out_parity, out_z, out_last, busy
  );
endinterface

// File: rtl/col_parity_theta_engine_mix.sv
// Theta mix of one line: each bit XORed with parity of the left column (this z)
// and of the right column (previous z); mode 1 bypasses the mix.
module col_parity_theta_mix import col_parity_pkg::*; #(
  parameter int ROWS   = 5,
  parameter int COLS   = 5,
  parameter int LINE_W = ROWS * COLS
) (
  input  logic [LINE_W-1:0] line,
  input  logic [COLS-1:0]   c_cur,
  input  logic [COLS-1:0]   c_prev,
  input  logic              mode,
  output logic [LINE_W-1:0] mixed
);
  for (genvar y = 0; y < ROWS; y++) begin : g_row
    for (genvar x = 0; x < COLS; x++) begin : g_col
      localparam int B  = idx(y, x, COLS);
      localparam int XL = (x + COLS - 1) % COLS;
      localparam int XR = (x + 1) % COLS;
      assign mixed[B] = mode ? line[B] : (line[B] ^ c_cur[XL] ^ c_prev[XR]);
    end
  end
endmodule

// File: rtl/col_parity_theta_engine.sv
// Buffers a DEPTH-line block with per-line column parity, then drains it
// ascending or descending with theta mixing or plain passthrough.
module col_parity_theta_engine import col_parity_pkg::*; #(
  parameter int ROWS  = 5,
  parameter int COLS  = 5,
  parameter int DEPTH = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  col_parity_theta_engine_if.slave  bus
);
  localparam int LINE_W = line_w(ROWS, COLS);
  localparam int CNT_W  = cnt_w(DEPTH);
  localparam logic [CNT_W-1:0] LAST_Z = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] ONE_Z  = CNT_W'(1);

  state_t            state;
  logic [CNT_W-1:0]  wr_cnt;
  logic [CNT_W-1:0]  rd_cnt;
  logic [CNT_W-1:0]  rd_prev;
  logic              mode_q;
  logic              dir_q;
  logic              out_valid_q;
  logic              busy_q;
  logic              accept;
  logic              fire;
  logic              last;
  logic [COLS-1:0]   par_in;
  logic [LINE_W-1:0] line_mem [DEPTH];
  logic [COLS-1:0]   par_mem  [DEPTH];

  assign accept  = (state == ST_LOAD) && bus.in_valid;
  assign last    = (state == ST_DRAIN) && (dir_q ? (rd_cnt == '0) : (rd_cnt == LAST_Z));
  assign fire    = out_valid_q && bus.out_ready;
  assign rd_prev = (rd_cnt == '0) ? LAST_Z : (rd_cnt - ONE_Z);

  always_comb begin
    par_in = '0;
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < COLS; x++)
        par_in[x] = par_in[x] ^ bus.in_line[idx(y, x, COLS)];
  end

  // Line storage is deliberately not reset; only writes are blocked during reset.
  always_ff @(posedge clk) begin
    if (!rst && accept) line_mem[wr_cnt] <= bus.in_line;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_LOAD;
      wr_cnt      <= '0;
      rd_cnt      <= '0;
      mode_q      <= 1'b0;
      dir_q       <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      for (int z = 0; z < DEPTH; z++) par_mem[z] <= '0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (accept) begin
            par_mem[wr_cnt] <= par_in;
            if (wr_cnt == '0) begin
              mode_q <= bus.mode;
              dir_q  <= bus.dir_down;
              busy_q <= 1'b1;
            end
            if (wr_cnt == LAST_Z) begin
              // DEPTH >= 2, so dir_q already holds this block's direction.
              wr_cnt      <= '0;
              state       <= ST_DRAIN;
              out_valid_q <= 1'b1;
              rd_cnt      <= dir_q ? LAST_Z : '0;
            end else begin
              wr_cnt <= wr_cnt + ONE_Z;
            end
          end
        end
        default: begin
          if (fire) begin
            if (last) begin
              state       <= ST_LOAD;
              out_valid_q <= 1'b0;
              busy_q      <= 1'b0;
              rd_cnt      <= '0;
            end else begin
              rd_cnt <= dir_q ? (rd_cnt - ONE_Z) : (rd_cnt + ONE_Z);
            end
          end
        end
      endcase
    end
  end

  col_parity_theta_mix #(.ROWS(ROWS), .COLS(COLS), .LINE_W(LINE_W)) u_mix (
    .line   (line_mem[rd_cnt]),
    .c_cur  (par_mem[rd_cnt]),
    .c_prev (par_mem[rd_prev]),
    .mode   (mode_q),
    .mixed  (bus.out_line)
  );

  assign bus.in_ready   = (state == ST_LOAD);
  assign bus.out_valid  = out_valid_q;
  assign bus.out_parity = par_mem[rd_cnt];
  assign bus.out_z      = rd_cnt;
  assign bus.out_last   = last;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_col_parity_theta_engine.sv
// Scoreboard bench for the column-parity theta engine (ROWS=COLS=5, DEPTH=4).
module tb_col_parity_theta_engine;
  localparam int ROWS = 5, COLS = 5, DEPTH = 4;

  typedef logic [24:0] blk_t [4];
  typedef struct {
    logic [24:0] line;
    logic [4:0]  par;
    logic [1:0]  z;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t sb [$];

  col_parity_theta_engine_if #(.ROWS(ROWS), .COLS(COLS), .DEPTH(DEPTH)) bus ();

  col_parity_theta_engine #(.ROWS(ROWS), .COLS(COLS), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] col_par(input logic [24:0] l);
    logic [4:0] p = '0;
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 5; x++) p[x] ^= l[y*5+x];
    return p;
  endfunction

  task automatic push_expected(input blk_t blk, input logic m, input logic d);
    logic [4:0] c [4];
    for (int z = 0; z < 4; z++) c[z] = col_par(blk[z]);
    for (int k = 0; k < 4; k++) begin
      exp_t e;
      int z;
      z = d ? 3 - k : k;
      e.z = 2'(z);
      e.par = c[z];
      e.last = (k == 3);
      for (int y = 0; y < 5; y++)
        for (int x = 0; x < 5; x++)
          e.line[y*5+x] = m ? blk[z][y*5+x]
                            : blk[z][y*5+x] ^ c[z][(x+4)%5] ^ c[(z+3)%4][(x+1)%5];
      sb.push_back(e);
    end
  endtask

  task automatic load_block(input blk_t blk, input logic m, input logic d);
    int guard;
    for (int z = 0; z < 4; z++) begin
      guard = 0;
      @(negedge clk);
      while (!bus.in_ready && guard < 50) begin @(negedge clk); guard++; end
      checks++;
      if (bus.in_ready !== 1'b1) begin
        errors++; $display("FAIL load_in_ready z=%0d got %b want 1", z, bus.in_ready);
      end
      bus.in_valid = 1'b1;
      bus.in_line  = blk[z];
      bus.mode     = (z == 0) ? m : ~m;
      bus.dir_down = (z == 0) ? d : ~d;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++; $display("FAIL out_valid_latency got %b want 1", bus.out_valid);
    end
    push_expected(blk, m, d);
  endtask

  task automatic drain_block(input int stall_at);
    int guard = 0;
    int cnt = 0;
    logic [24:0] snap_line;
    logic [1:0]  snap_z;
    exp_t e;
    while (sb.size() > 0 && guard < 200) begin
      @(negedge clk);
      guard++;
      if (bus.out_valid) begin
        if (cnt == stall_at) begin
          bus.out_ready = 1'b0;
          bus.in_valid  = 1'b1;
          bus.in_line   = 25'h1abcdef;
          snap_line = bus.out_line;
          snap_z    = bus.out_z;
          repeat (3) begin
            @(negedge clk);
            checks++;
            if (bus.out_line !== snap_line || bus.out_z !== snap_z || bus.in_ready !== 1'b0) begin
              errors++;
              $display("FAIL stall_hold line %h z %0d in_ready %b want line %h z %0d in_ready 0",
                       bus.out_line, bus.out_z, bus.in_ready, snap_line, snap_z);
            end
          end
          bus.in_valid = 1'b0;
        end
        e = sb.pop_front();
        checks++;
        if (bus.out_line !== e.line || bus.out_parity !== e.par ||
            bus.out_z !== e.z || bus.out_last !== e.last) begin
          errors++;
          $display("FAIL drain_beat%0d got line %h par %h z %0d last %b want line %h par %h z %0d last %b",
                   cnt, bus.out_line, bus.out_parity, bus.out_z, bus.out_last,
                   e.line, e.par, e.z, e.last);
        end
        bus.out_ready = 1'b1;
        cnt++;
      end
    end
    if (sb.size() > 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout got %0d beats left want 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
    bus.out_ready = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL block_end busy %b out_valid %b in_ready %b want 0 0 1",
               bus.busy, bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
        bus.out_last !== 1'b0 || bus.out_z !== 2'd0 || bus.out_parity !== 5'd0) begin
      errors++;
      $display("FAIL reset_state in_ready %b out_valid %b busy %b last %b z %0d par %h want 1 0 0 0 0 00",
               bus.in_ready, bus.out_valid, bus.busy, bus.out_last, bus.out_z, bus.out_parity);
    end
  endtask

  task automatic test_all_zero();
    blk_t b = '{default: 25'h0};
    load_block(b, 1'b0, 1'b0);
    drain_block(-1);
  endtask

  task automatic test_single_bit_mix();
    blk_t b = '{25'h1, 25'h0, 25'h0, 25'h0};
    load_block(b, 1'b0, 1'b0);
    drain_block(-1);
  endtask

  task automatic test_passthrough_down();
    blk_t b = '{25'h1, 25'h0, 25'h0, 25'h0};
    load_block(b, 1'b1, 1'b1);
    drain_block(-1);
  endtask

  task automatic test_z_wrap();
    blk_t b = '{25'h0, 25'h0, 25'h0, 25'h1};
    load_block(b, 1'b0, 1'b0);
    drain_block(-1);
  endtask

  task automatic test_stall();
    blk_t b;
    for (int z = 0; z < 4; z++) b[z] = 25'($urandom);
    load_block(b, 1'b0, 1'b1);
    drain_block(1);
  endtask

  task automatic test_back_to_back();
    blk_t b;
    for (int n = 0; n < 3; n++) begin
      for (int z = 0; z < 4; z++) b[z] = 25'($urandom);
      load_block(b, n[0], n[1]);
      drain_block(-1);
    end
  endtask

  task automatic test_reset_mid_load();
    blk_t b;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_line = 25'h1555555; bus.mode = 1'b1; bus.dir_down = 1'b1;
    @(negedge clk);
    bus.in_line = 25'h0aaaaaa;
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++; $display("FAIL busy_mid_load got %b want 1", bus.busy);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_mid_load busy %b in_ready %b want 0 1", bus.busy, bus.in_ready);
    end
    for (int z = 0; z < 4; z++) b[z] = 25'($urandom);
    load_block(b, 1'b0, 1'b0);
    drain_block(-1);
  endtask

  initial begin
    bus.mode = 1'b0; bus.dir_down = 1'b0; bus.in_valid = 1'b0;
    bus.in_line = '0; bus.out_ready = 1'b0;
    test_reset();
    test_all_zero();
    test_single_bit_mix();
    test_passthrough_down();
    test_z_wrap();
    test_stall();
    test_back_to_back();
    test_reset_mid_load();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
